// File: rtl/booth2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | booth2_pkg                                                                 |
// | Shared types for the iterative radix-4 Booth multiplier.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package booth2_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ZERO   = 3'd0,
        POS_A  = 3'd1,
        POS_2A = 3'd2,
        NEG_2A = 3'd3,
        NEG_A  = 3'd4
    } booth_op_t;

    function automatic booth_op_t booth_decode(input logic [2:0] code);
        booth_op_t op;
        case (code)
            3'b001, 3'b010: op = POS_A;
            3'b011:         op = POS_2A;
            3'b100:         op = NEG_2A;
            3'b101, 3'b110: op = NEG_A;
            default:        op = ZERO;
        endcase
        return op;
    endfunction

endpackage : booth2_pkg
`default_nettype wire

// File: rtl/booth2_group_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | booth2_group_sel                                                           |
// | Maps one radix-4 Booth code plus A / -A to a signed partial product.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module booth2_group_sel
    import booth2_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2:0]     i_code,
    input  logic [WIDTH:0] i_a_ext,
    input  logic [WIDTH:0] i_neg_a,
    output logic [WIDTH+1:0] o_pp
);

    // One extra bit beyond WIDTH+1 so that -2A with A = -2^(WIDTH-1) stays positive.
    always_comb begin
        o_pp = '0;
        case (booth_decode(i_code))
            POS_A:   o_pp = {i_a_ext[WIDTH], i_a_ext};
            POS_2A:  o_pp = {i_a_ext, 1'b0};
            NEG_2A:  o_pp = {i_neg_a, 1'b0};
            NEG_A:   o_pp = {i_neg_a[WIDTH], i_neg_a};
            default: o_pp = '0;
        endcase
    end

endmodule : booth2_group_sel
`default_nettype wire

// File: rtl/booth2_seq_mult_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | booth2_seq_mult_ctrl                                                       |
// | Iterative radix-4 Booth signed multiplier, one group per cycle.            |
// | Optional macro BOOTH_EARLY_TERM_EN: finish once remaining groups are zero. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module booth2_seq_mult_ctrl
    import booth2_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A_NUM,
    input  logic [WIDTH-1:0]     B_NUM,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   PRODUCT,
    output logic                 busy
);

    localparam int GROUPS = WIDTH / 2;
    localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int PP_W   = WIDTH + 2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GROUPS - 1);

    state_t               r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH:0]       r_b_sh;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_busy;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH:0]       w_a_ext;
    logic [WIDTH:0]       w_neg_a;
    logic [PP_W-1:0]      w_pp;
    logic [2*WIDTH-1:0]   w_pp_shift;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [WIDTH:0]       w_b_next;
    logic                 w_finish;

    assign w_a_ext    = {r_a[WIDTH-1], r_a};
    assign w_neg_a    = -w_a_ext;
    assign w_pp_shift = {{(2*WIDTH-PP_W){w_pp[PP_W-1]}}, w_pp} << {r_cnt, 1'b0};
    assign w_acc_next = r_acc + w_pp_shift;
    assign w_b_next   = {r_b_sh[WIDTH], r_b_sh[WIDTH], r_b_sh[WIDTH:2]};

`ifdef BOOTH_EARLY_TERM_EN
    // Uniform remaining bits decode to code 000/111 in every later group.
    assign w_finish = (r_cnt == LAST_CNT) || (w_b_next == '0) || (&w_b_next);
`else
    assign w_finish = (r_cnt == LAST_CNT);
`endif

    booth2_group_sel #(
        .WIDTH (WIDTH)
    ) u_group_sel (
        .i_code  (r_b_sh[2:0]),
        .i_a_ext (w_a_ext),
        .i_neg_a (w_neg_a),
        .o_pp    (w_pp)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b_sh      <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_product   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= A_NUM;
                        r_b_sh     <= {B_NUM, 1'b0};
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    r_acc  <= w_acc_next;
                    r_b_sh <= w_b_next;
                    if (w_finish) begin
                        r_product   <= w_acc_next;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign PRODUCT   = r_product;

endmodule : booth2_seq_mult_ctrl
`default_nettype wire
